// File: rtl/spi_cmd_responder_pkg.sv
// Shared spi_slave control-port map, command-word field layout and responder FSM encoding.
package spi_cmd_responder_pkg;

    localparam int SPI_ADDR_W = 3;
    localparam int SPI_DATA_W = 32;

    localparam logic [SPI_ADDR_W-1:0] SPI_TX         = 3'd0;
    localparam logic [SPI_ADDR_W-1:0] SPI_RX         = 3'd1;
    localparam logic [SPI_ADDR_W-1:0] SPI_READY      = 3'd2;
    localparam logic [SPI_ADDR_W-1:0] SPI_INTRRPT_EN = 3'd3;

    // Command word layout: opcode[31:30], index[27:24], payload[15:0]
    localparam int CMD_OPC_LSB = 30;
    localparam int CMD_IDX_LSB = 24;
    localparam int CMD_PAY_W   = 16;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_ECHO  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_CHK    = 3'd2,
        ST_RD_RX  = 3'd3,
        ST_RD_CAP = 3'd4,
        ST_EXEC   = 3'd5,
        ST_WR_TX  = 3'd6
    } state_e;

endpackage

// File: rtl/spi_rsp_regfile.sv
// Responder register file: one write port, two combinational read ports, synchronous clear.
module spi_rsp_regfile #(
    parameter int NREGS_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [NREGS_W-1:0] i_waddr,
    input  logic [31:0]        i_wdata,
    input  logic [NREGS_W-1:0] i_raddr_a,
    output logic [31:0]        o_rdata_a,
    input  logic [NREGS_W-1:0] i_raddr_b,
    output logic [31:0]        o_rdata_b
);

    logic [31:0] r_mem [2**NREGS_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**NREGS_W; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/spi_cmd_responder.sv
// Command responder on the spi_slave control port: fetch word, execute, write response.
// Define SPI_RSP_INTRRPT_EN for interrupt-driven fetch instead of polling SPI_READY.
module spi_cmd_responder
    import spi_cmd_responder_pkg::*;
#(
    parameter int NREGS_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [SPI_ADDR_W-1:0] address,
    output logic [SPI_DATA_W-1:0] data_in,
    input  logic [SPI_DATA_W-1:0] data_out,
    output logic                  sel,
    output logic                  we,
    input  logic                  interrupt,
    input  logic [NREGS_W-1:0]    reg_raddr,
    output logic [31:0]           reg_rdata,
    output logic [15:0]           cmd_cnt,
    output logic                  busy
);

    state_e                r_state;
    logic                  r_sel;
    logic                  r_we;
    logic [SPI_ADDR_W-1:0] r_addr;
    logic [SPI_DATA_W-1:0] r_data_in;
    logic [31:0]           r_rx_word;
    logic [15:0]           r_cmd_cnt;

    opcode_e               w_opcode;
    logic [NREGS_W-1:0]    w_idx;
    logic                  w_rf_we;
    logic [31:0]           w_exec_rdata;
    logic [31:0]           w_response;

    assign w_opcode = opcode_e'(r_rx_word[CMD_OPC_LSB +: 2]);
    assign w_idx    = r_rx_word[CMD_IDX_LSB +: NREGS_W];
    assign w_rf_we  = (r_state == ST_EXEC) && (w_opcode == OP_WRITE);

    spi_rsp_regfile #(.NREGS_W(NREGS_W)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_rf_we),
        .i_waddr   (w_idx),
        .i_wdata   ({16'h0, r_rx_word[CMD_PAY_W-1:0]}),
        .i_raddr_a (w_idx),
        .o_rdata_a (w_exec_rdata),
        .i_raddr_b (reg_raddr),
        .o_rdata_b (reg_rdata)
    );

    // READ returns the entry as it stood before this EXEC's write edge.
    always_comb begin
        w_response = '0;
        case (w_opcode)
            OP_READ: w_response = w_exec_rdata;
            OP_ECHO: w_response = r_rx_word;
            default: w_response = '0;
        endcase
    end

`ifdef SPI_RSP_INTRRPT_EN
    logic r_init_done;
`else
    logic w_unused_intr;
    assign w_unused_intr = interrupt;
`endif

    // Bus outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_sel     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data_in <= '0;
            r_rx_word <= '0;
            r_cmd_cnt <= '0;
`ifdef SPI_RSP_INTRRPT_EN
            r_init_done <= 1'b0;
`endif
        end else begin
            case (r_state)
`ifdef SPI_RSP_INTRRPT_EN
                ST_INIT: begin
                    if (!r_init_done) begin
                        r_init_done <= 1'b1;
                        r_sel       <= 1'b1;
                        r_we        <= 1'b1;
                        r_addr      <= SPI_INTRRPT_EN;
                        r_data_in   <= 32'd1;
                    end else begin
                        r_state   <= ST_WAIT;
                        r_sel     <= 1'b0;
                        r_we      <= 1'b0;
                        r_addr    <= '0;
                        r_data_in <= '0;
                    end
                end
                ST_WAIT: begin
                    if (interrupt) begin
                        r_state <= ST_RD_RX;
                        r_sel   <= 1'b1;
                        r_addr  <= SPI_RX;
                    end
                end
`else
                ST_INIT: begin
                    r_state <= ST_WAIT;
                    r_sel   <= 1'b1;
                    r_addr  <= SPI_READY;
                end
                ST_WAIT: begin
                    r_state <= ST_CHK;
                end
                ST_CHK: begin
                    if (data_out != '0) begin
                        r_state <= ST_RD_RX;
                        r_addr  <= SPI_RX;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
`endif
                ST_RD_RX: begin
                    r_state <= ST_RD_CAP;
                    r_sel   <= 1'b0;
                end
                ST_RD_CAP: begin
                    r_state   <= ST_EXEC;
                    r_rx_word <= data_out;
                end
                ST_EXEC: begin
                    r_state   <= ST_WR_TX;
                    r_cmd_cnt <= r_cmd_cnt + 16'd1;
                    r_sel     <= 1'b1;
                    r_we      <= 1'b1;
                    r_addr    <= SPI_TX;
                    r_data_in <= w_response;
                end
                ST_WR_TX: begin
                    r_state   <= ST_WAIT;
                    r_we      <= 1'b0;
                    r_data_in <= '0;
`ifdef SPI_RSP_INTRRPT_EN
                    r_sel     <= 1'b0;
                    r_addr    <= '0;
`else
                    r_addr    <= SPI_READY;
`endif
                end
                default: begin
                    r_state <= ST_INIT;
                    r_sel   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the bus immediately so an in-flight TX write is dropped.
    assign sel     = r_sel & ~rst;
    assign we      = r_we & ~rst;
    assign address = rst ? '0 : r_addr;
    assign data_in = rst ? '0 : r_data_in;
    assign cmd_cnt = r_cmd_cnt;
    assign busy    = rst | (r_state != ST_WAIT);

endmodule
